// File: rtl/shape_edge_emitter.sv
// shape_edge_emitter: takes one 172-bit SPU draw packet per valid/ready handshake
// and streams out the closed polygon outline as edge segments (v[i] -> v[i+1],
// the last edge wraps back to v[0]). Feeds the line rasterizer.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   pkt_valid/pkt_ready packet handshake; pkt_ready is high only in IDLE
//   pkt[171:0]          {shape[1:0], code[3:0], color[5:0], vertices[159:0]}
//   seg_valid/seg_ready segment handshake
//   seg_x0/y0/x1/y1     segment end points, seg_color, seg_last (closing edge)
//   busy                high while a draw packet is being processed
//   done                one-cycle pulse after the last segment is accepted
//   drop_count          saturating count of packets whose code != DRAW_CODE
module shape_edge_emitter #(
    parameter logic [3:0]  DRAW_CODE  = 4'b0101,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [171:0]          pkt,
    output logic                  seg_valid,
    input  logic                  seg_ready,
    output logic [7:0]            seg_x0,
    output logic [7:0]            seg_y0,
    output logic [7:0]            seg_x1,
    output logic [7:0]            seg_y1,
    output logic [5:0]            seg_color,
    output logic                  seg_last,
    output logic                  busy,
    output logic                  done,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned VTX_W   = 16;
    localparam int unsigned NUM_VTX = 10;
    localparam int unsigned VERTS_W = VTX_W * NUM_VTX;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           shape_q;
    logic [5:0]           color_q;
    logic [VERTS_W-1:0]   verts_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     n_q, n_d;
    logic [DROP_CNT_W-1:0] drop_d;
    logic                 capture;
    logic                 load_seg;
    logic                 seg_valid_d;
    logic                 done_d;
    logic [IDX_W-1:0]     seg_sel;
    logic [IDX_W-1:0]     seg_inc;
    logic [IDX_W-1:0]     seg_end;
    logic                 seg_last_d;
    logic [VTX_W-1:0]     vtx [NUM_VTX];

    // Vertex count encoded by the shape field.
    function automatic logic [IDX_W-1:0] shape_n(input logic [1:0] s);
        case (s)
            2'b00:   return IDX_W'(3);
            2'b01:   return IDX_W'(4);
            2'b10:   return IDX_W'(5);
            default: return IDX_W'(8);
        endcase
    endfunction

    // Unpack the captured vertex slots; x is the upper byte, y the lower.
    always_comb begin
        for (int i = 0; i < NUM_VTX; i++) begin
            vtx[i] = verts_q[VTX_W*i +: VTX_W];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        drop_d      = drop_count;
        capture     = 1'b0;
        load_seg    = 1'b0;
        seg_sel     = idx_q;
        seg_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    capture = 1'b1;
                    if (pkt[169:166] == DRAW_CODE) begin
                        state_d = LOAD;
                    end else if (drop_count != {DROP_CNT_W{1'b1}}) begin
                        drop_d = drop_count + DROP_CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                idx_d       = '0;
                n_d         = shape_n(shape_q);
                seg_sel     = '0;
                load_seg    = 1'b1;
                seg_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                seg_valid_d = 1'b1;
                if (seg_ready) begin
                    if (seg_last) begin
                        seg_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        seg_sel  = idx_d;
                        load_seg = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End vertex of the segment being loaded wraps to v[0] on the closing edge.
        seg_inc    = IDX_W'(seg_sel + IDX_W'(1));
        seg_end    = (seg_inc == n_d) ? '0 : seg_inc;
        seg_last_d = (seg_sel == IDX_W'(n_d - IDX_W'(1)));
    end

    // State and registered outputs; seg_* only change when a new segment is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shape_q    <= '0;
            color_q    <= '0;
            verts_q    <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            drop_count <= '0;
            pkt_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            seg_valid  <= 1'b0;
            seg_x0     <= '0;
            seg_y0     <= '0;
            seg_x1     <= '0;
            seg_y1     <= '0;
            seg_color  <= '0;
            seg_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            drop_count <= drop_d;
            pkt_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            done       <= done_d;
            seg_valid  <= seg_valid_d;
            if (capture) begin
                shape_q <= pkt[171:170];
                color_q <= pkt[165:160];
                verts_q <= pkt[159:0];
            end
            if (load_seg) begin
                seg_x0    <= vtx[seg_sel][15:8];
                seg_y0    <= vtx[seg_sel][7:0];
                seg_x1    <= vtx[seg_end][15:8];
                seg_y1    <= vtx[seg_end][7:0];
                seg_color <= color_q;
                seg_last  <= seg_last_d;
            end
        end
    end

endmodule
